// File: rtl/dm_mmio_bridge_if.sv
// Core data-memory port plus the BRAM port it fans out to, grouped as one bus.
// master = core/BRAM side (testbench), slave = dm_mmio_bridge.
interface dm_mmio_bridge_if #(
  parameter int WIDTH       = 32,
  parameter int BRAM_ADDR_W = 12
);
  logic                   dm_we;
  logic [WIDTH-1:0]       dm_addr;
  logic [WIDTH-1:0]       dm_wdata;
  logic [WIDTH-1:0]       dm_rdata;
  logic                   mem_stall;
  logic                   bram_we;
  logic [BRAM_ADDR_W-1:0] bram_addr;
  logic [WIDTH-1:0]       bram_wdata;
  logic [WIDTH-1:0]       bram_rdata;

  modport master (
    output dm_we, dm_addr, dm_wdata, mem_stall, bram_rdata,
    input  dm_rdata, bram_we, bram_addr, bram_wdata
  );

  modport slave (
    input  dm_we, dm_addr, dm_wdata, mem_stall, bram_rdata,
    output dm_rdata, bram_we, bram_addr, bram_wdata
  );
endinterface

// File: rtl/dm_mmio_bridge.sv
// Data-memory bridge: routes MEM-stage accesses to BRAM or an MMIO page (LED, UART TX,
// STATUS, CYCLES). Define DM_MMIO_CYCLE_COUNTER_EN to build the cycle counter at +0xC.
module dm_mmio_bridge #(
  parameter int               WIDTH        = 32,
  parameter int               BRAM_ADDR_W  = 12,
  parameter int               CLKS_PER_BIT = 868,
  parameter logic [WIDTH-1:0] MMIO_BASE    = 32'hFFFF_0000
) (
  input  logic             clk,
  input  logic             rst,
  dm_mmio_bridge_if.slave  bus,
  output logic [7:0]       led,
  output logic             uart_tx,
  output logic             bus_err
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uartStateT;

  uartStateT         state, stateNext;
  logic [BAUD_W-1:0] baudCnt, baudNext;
  logic [2:0]        bitIdx, bitIdxNext;
  logic [7:0]        shiftReg, shiftNext;
  logic              txNext;
  logic              baudDone;

  logic             isBram, isMmio, isUnmapped;
  logic [1:0]       regSel;
  logic             commit;
  logic             ledWr, txWr, statWr;
  logic             busy, txStart, txDrop, errSet;
  logic             overflow;
  logic [WIDTH-1:0] cyclesRd;
  logic [WIDTH-1:0] rdata;
  logic             unusedAddrBits;

  assign isBram     = (bus.dm_addr[WIDTH-1:BRAM_ADDR_W+2] == '0);
  assign isMmio     = (bus.dm_addr[WIDTH-1:4] == MMIO_BASE[WIDTH-1:4]);
  assign isUnmapped = !isBram && !isMmio;
  assign regSel     = bus.dm_addr[3:2];
  assign unusedAddrBits = ^bus.dm_addr[1:0];

  // BRAM path is pure passthrough; stalled repeats of a store rewrite the same word.
  assign bus.bram_we    = bus.dm_we && isBram;
  assign bus.bram_addr  = bus.dm_addr[BRAM_ADDR_W+1:2];
  assign bus.bram_wdata = bus.dm_wdata;

  // Side effects only on the instruction's last MEM cycle.
  assign commit  = !bus.mem_stall;
  assign ledWr   = commit && bus.dm_we && isMmio && (regSel == 2'd0);
  assign txWr    = commit && bus.dm_we && isMmio && (regSel == 2'd1);
  assign statWr  = commit && bus.dm_we && isMmio && (regSel == 2'd2);
  assign errSet  = commit && isUnmapped;
  assign busy    = (state != IDLE);
  assign txStart = txWr && !busy;
  assign txDrop  = txWr && busy;

  always_comb begin
    rdata = '0;
    if (isBram) begin
      rdata = bus.bram_rdata;
    end else if (isMmio) begin
      unique case (regSel)
        2'd0: rdata = WIDTH'(led);
        2'd1: rdata = '0;
        2'd2: rdata = WIDTH'({bus_err, overflow, busy});
        2'd3: rdata = cyclesRd;
      endcase
    end
  end
  assign bus.dm_rdata = rdata;

  // Set wins over a same-edge clear for both sticky flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led      <= '0;
      overflow <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      if (ledWr) led <= bus.dm_wdata[7:0];
      if (txDrop) overflow <= 1'b1;
      else if (statWr && bus.dm_wdata[1]) overflow <= 1'b0;
      if (errSet) bus_err <= 1'b1;
      else if (statWr && bus.dm_wdata[2]) bus_err <= 1'b0;
    end
  end

`ifdef DM_MMIO_CYCLE_COUNTER_EN
  logic [WIDTH-1:0] cycles;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cycles <= '0;
    else     cycles <= cycles + 1'b1;
  end
  assign cyclesRd = cycles;
`else
  assign cyclesRd = '0;
`endif

  assign baudDone = (baudCnt == BAUD_W'(CLKS_PER_BIT - 1));

  // uart_tx is registered, so the next line level is derived from the next state.
  always_comb begin
    stateNext  = state;
    baudNext   = baudCnt + 1'b1;
    bitIdxNext = bitIdx;
    shiftNext  = shiftReg;
    txNext     = uart_tx;
    unique case (state)
      IDLE: begin
        baudNext = '0;
        txNext   = 1'b1;
        if (txStart) begin
          stateNext = START;
          shiftNext = bus.dm_wdata[7:0];
          txNext    = 1'b0;
        end
      end
      START: begin
        if (baudDone) begin
          stateNext  = DATA;
          baudNext   = '0;
          bitIdxNext = 3'd0;
          txNext     = shiftReg[0];
        end
      end
      DATA: begin
        if (baudDone) begin
          baudNext = '0;
          if (bitIdx == 3'd7) begin
            stateNext = STOP;
            txNext    = 1'b1;
          end else begin
            bitIdxNext = bitIdx + 3'd1;
            shiftNext  = shiftReg >> 1;
            txNext     = shiftReg[1];
          end
        end
      end
      STOP: begin
        if (baudDone) begin
          stateNext = IDLE;
          baudNext  = '0;
          txNext    = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      baudCnt <= '0;
      bitIdx  <= '0;
      uart_tx <= 1'b1;
    end else begin
      state   <= stateNext;
      baudCnt <= baudNext;
      bitIdx  <= bitIdxNext;
      uart_tx <= txNext;
    end
  end

  always_ff @(posedge clk) begin
    shiftReg <= shiftNext;
  end

endmodule

// File: tb/tb_dm_mmio_bridge.sv
// Directed bench for dm_mmio_bridge with a queue scoreboard of expected values.
module tb_dm_mmio_bridge;

  localparam int W   = 32;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] led;
  logic       uartTx;
  logic       busErr;

  always #5 clk = ~clk;

  dm_mmio_bridge_if #(.WIDTH(W), .BRAM_ADDR_W(12)) bus ();

  dm_mmio_bridge #(
    .WIDTH(W), .BRAM_ADDR_W(12), .CLKS_PER_BIT(CPB), .MMIO_BASE(32'hFFFF_0000)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .led(led), .uart_tx(uartTx), .bus_err(busErr)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } expT;

  expT sb[$];
  int  total = 0;
  int  bad   = 0;

  task automatic pushExp(input string tag, input logic [31:0] val);
    expT e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic popChk(input logic [31:0] obs);
    expT e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_empty observed=%08h required=<none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        bad++;
        $error("FAIL %s observed=%08h expected=%08h", e.tag, obs, e.val);
      end
    end
  endtask

  // Drive one cycle of core inputs on the falling edge, then settle.
  task automatic drv(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic stall);
    @(negedge clk);
    bus.dm_we     = we;
    bus.dm_addr   = addr;
    bus.dm_wdata  = wdata;
    bus.mem_stall = stall;
    #1;
  endtask

  localparam logic [31:0] LED_A  = 32'hFFFF_0000;
  localparam logic [31:0] TX_A   = 32'hFFFF_0004;
  localparam logic [31:0] STAT_A = 32'hFFFF_0008;
  localparam logic [31:0] CYC_A  = 32'hFFFF_000C;

  logic [9:0]  frame;
  logic [31:0] c1, c2;

  initial begin
    rst            = 1'b1;
    bus.dm_we      = 1'b0;
    bus.dm_addr    = '0;
    bus.dm_wdata   = '0;
    bus.mem_stall  = 1'b0;
    bus.bram_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    pushExp("rst_uart_tx", 32'd1);  popChk({31'd0, uartTx});
    pushExp("rst_led", 32'd0);      popChk({24'd0, led});
    pushExp("rst_bus_err", 32'd0);  popChk({31'd0, busErr});
    rst = 1'b0;

    // Reads right after reset
    drv(0, LED_A, 0, 0);
    pushExp("rd_led", 32'd0);       popChk(bus.dm_rdata);
    drv(0, STAT_A, 0, 0);
    pushExp("rd_status", 32'd0);    popChk(bus.dm_rdata);
    bus.bram_rdata = 32'h1234;
    drv(0, 32'h0000_0010, 0, 0);
    pushExp("rd_bram", 32'h1234);   popChk(bus.dm_rdata);
    pushExp("bram_addr", 32'd4);    popChk({20'd0, bus.bram_addr});
    pushExp("idle_uart_tx", 32'd1); popChk({31'd0, uartTx});
    pushExp("idle_bus_err", 32'd0); popChk({31'd0, busErr});

    // BRAM store passes through even while stalled
    drv(1, 32'h0000_0010, 32'hDEAD_BEEF, 1);
    pushExp("bram_we_stall", 32'd1);     popChk({31'd0, bus.bram_we});
    pushExp("bram_wdata", 32'hDEAD_BEEF); popChk(bus.bram_wdata);

    // LED store held by a 3-cycle stall
    drv(1, LED_A, 32'hA5, 1);
    pushExp("led_mmio_bram_we", 32'd0); popChk({31'd0, bus.bram_we});
    drv(1, LED_A, 32'hA5, 1);
    pushExp("led_stall1", 32'd0);   popChk({24'd0, led});
    drv(1, LED_A, 32'hA5, 1);
    pushExp("led_stall2", 32'd0);   popChk({24'd0, led});
    drv(1, LED_A, 32'hA5, 0);
    pushExp("led_stall3", 32'd0);   popChk({24'd0, led});
    drv(0, LED_A, 0, 0);
    pushExp("led_commit", 32'hA5);  popChk({24'd0, led});
    pushExp("led_readback", 32'hA5); popChk(bus.dm_rdata);

    // UART frame for 0x55: start, 8 data LSB first, stop
    frame = {1'b1, 8'h55, 1'b0};
    drv(1, TX_A, 32'h55, 0);
    for (int i = 0; i < 10 * CPB; i++) begin
      drv(0, STAT_A, 0, 0);
      pushExp($sformatf("tx_bit%0d_s%0d", i / CPB, i % CPB), {31'd0, frame[i / CPB]});
      popChk({31'd0, uartTx});
      if (i == 20) begin
        pushExp("status_busy", 32'd1); popChk(bus.dm_rdata);
      end
    end
    drv(0, STAT_A, 0, 0);
    pushExp("status_after_frame", 32'd0); popChk(bus.dm_rdata);
    pushExp("tx_idle_after", 32'd1);      popChk({31'd0, uartTx});

    // Write while busy is dropped and flags overflow; W1C clears it
    drv(1, TX_A, 32'hC3, 0);
    drv(1, TX_A, 32'h0F, 0);
    drv(0, STAT_A, 0, 0);
    pushExp("status_overflow", 32'd3); popChk(bus.dm_rdata);
    drv(1, STAT_A, 32'h2, 0);
    drv(0, STAT_A, 0, 0);
    pushExp("status_ovf_clr", 32'd1);  popChk(bus.dm_rdata);
    repeat (10 * CPB + 4) drv(0, STAT_A, 0, 0);
    pushExp("status_idle2", 32'd0);    popChk(bus.dm_rdata);

    // Unmapped store sets bus_err; W1C clears
    drv(1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    pushExp("unmapped_bram_we", 32'd0); popChk({31'd0, bus.bram_we});
    pushExp("unmapped_rdata", 32'd0);   popChk(bus.dm_rdata);
    drv(0, STAT_A, 0, 0);
    pushExp("bus_err_set", 32'd1);      popChk({31'd0, busErr});
    pushExp("status_bus_err", 32'd4);   popChk(bus.dm_rdata);
    drv(1, STAT_A, 32'h4, 0);
    drv(0, STAT_A, 0, 0);
    pushExp("bus_err_clr", 32'd0);      popChk({31'd0, busErr});

    // Stalled unmapped read must not commit; unstalled one must
    drv(0, 32'h4000_0000, 0, 1);
    drv(0, 32'h4000_0000, 0, 1);
    drv(0, STAT_A, 0, 0);
    pushExp("stall_rd_no_err", 32'd0);  popChk({31'd0, busErr});
    drv(0, 32'h4000_0000, 0, 0);
    drv(0, STAT_A, 0, 0);
    pushExp("unmapped_rd_err", 32'd1);  popChk({31'd0, busErr});
    drv(1, STAT_A, 32'h4, 0);
    drv(0, LED_A, 0, 0);
    pushExp("bus_err_clr2", 32'd0);     popChk({31'd0, busErr});

    // Cycle counter: two reads 10 cycles apart
    drv(0, CYC_A, 0, 0);
    c1 = bus.dm_rdata;
    repeat (9) drv(0, CYC_A, 0, 0);
    drv(0, CYC_A, 0, 0);
    c2 = bus.dm_rdata;
`ifdef DM_MMIO_CYCLE_COUNTER_EN
    pushExp("cycles_delta", 32'd10);    popChk(c2 - c1);
`else
    pushExp("cycles_rd1", 32'd0);       popChk(c1);
    pushExp("cycles_rd2", 32'd0);       popChk(c2);
`endif
    drv(1, CYC_A, 32'h1234_5678, 0);
    drv(0, STAT_A, 0, 0);
    pushExp("cycles_wr_no_err", 32'd0); popChk({31'd0, busErr});

    // Asynchronous reset in the middle of a frame
    drv(1, TX_A, 32'h00, 0);
    repeat (3) drv(0, LED_A, 0, 0);
    pushExp("tx_mid_frame", 32'd0);     popChk({31'd0, uartTx});
    #2 rst = 1'b1;
    #1;
    pushExp("tx_async_rst", 32'd1);     popChk({31'd0, uartTx});
    pushExp("led_async_rst", 32'd0);    popChk({24'd0, led});
    @(negedge clk);
    rst = 1'b0;
    drv(0, STAT_A, 0, 0);
    pushExp("status_after_rst", 32'd0); popChk(bus.dm_rdata);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
